// File: rtl/piso_serializer_pkg.sv
// Shared serial-link definitions: FSM state encoding and frame-length derivation.
// Optional parity bit selected by the PISO_PARITY_EN macro.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Bits on the wire per word; receivers derive their frame length from this too.
    function automatic int frame_len(input int width);
        return width + (PARITY_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: first bit registered one cycle after accept, one bit per cycle.
// Ready only when idle or on the last frame bit; PISO_PARITY_EN appends an even-parity bit.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CW    = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             ser_last_q;

    logic             at_last;
    logic             accept;
    logic [CW-1:0]    cnt_d;
    logic             load_head;
    logic [WIDTH-1:0] load_adv;
    logic             shreg_head;
    logic [WIDTH-1:0] shreg_adv;
    logic             next_bit;

    assign at_last    = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
    assign load_ready = (state_q == ST_IDLE) || at_last;
    assign accept     = load_valid && load_ready;
    assign cnt_d      = cnt_q + 1'b1;

    // The head bit goes straight to ser_out on accept, so the register holds the remainder.
    assign load_head  = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign load_adv   = MSB_FIRST ? (load_data << 1) : (load_data >> 1);
    assign shreg_head = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_adv  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^load_data;
        end
    end

    assign next_bit = (cnt_q == DATA_LAST) ? parity_q : shreg_head;
`else
    assign next_bit = shreg_head;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else if (accept) begin
            state_q     <= ST_SHIFT;
            shreg_q     <= load_adv;
            cnt_q       <= '0;
            ser_out_q   <= load_head;
            ser_valid_q <= 1'b1;
            ser_last_q  <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (at_last) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                ser_out_q   <= 1'b0;
                ser_valid_q <= 1'b0;
                ser_last_q  <= 1'b0;
            end else begin
                shreg_q     <= shreg_adv;
                cnt_q       <= cnt_d;
                ser_out_q   <= next_bit;
                ser_valid_q <= 1'b1;
                ser_last_q  <= (cnt_d == LAST_IDX);
            end
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4, MSB first); honours PISO_PARITY_EN for frame length.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_data = 4'h0;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;

    int errors = 0;
    int checks = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"}, {31'd0, ser_valid}, 32'd0);
        chk({tag, "_out"}, {31'd0, ser_out}, 32'd0);
        chk({tag, "_last"}, {31'd0, ser_last}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, load_ready}, 32'd1);
    endtask

    // Called in the first bit cycle of a frame of word w; offers (nv, nw) during its last bit.
    task automatic frame(input logic [3:0] w, input string tag, input logic nv, input logic [3:0] nw);
        logic exp_bit;
        load_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            exp_bit = (i < 4) ? w[3 - i] : ^w;
            chk($sformatf("%s_vld%0d", tag, i), {31'd0, ser_valid}, 32'd1);
            chk($sformatf("%s_out%0d", tag, i), {31'd0, ser_out}, {31'd0, exp_bit});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, ser_last}, {31'd0, (i == FRAME - 1)});
            chk($sformatf("%s_rdy%0d", tag, i), {31'd0, load_ready}, {31'd0, (i == FRAME - 1)});
            if (i == FRAME - 1) begin
                load_valid = nv;
                load_data  = nw;
            end
            tick();
        end
        load_valid = 1'b0;
    endtask

    initial begin
        // 1: reset holds outputs low and drops the offered word
        rst = 1'b1; load_valid = 1'b1; load_data = 4'b1111;
        tick();
        chk("rst_vld0", {31'd0, ser_valid}, 32'd0);
        chk("rst_out0", {31'd0, ser_out}, 32'd0);
        tick();
        chk("rst_vld1", {31'd0, ser_valid}, 32'd0);
        chk("rst_out1", {31'd0, ser_out}, 32'd0);
        rst = 1'b0; load_valid = 1'b0;
        chk("rst_rdy", {31'd0, load_ready}, 32'd1);
        tick();
        chk_idle("post_rst");
        tick();
        chk_idle("post_rst2");

        // 2: single word 1101 -> 1,1,0,1
        load_valid = 1'b1; load_data = 4'b1101;
        tick();
        frame(4'b1101, "single", 1'b0, 4'h0);
        chk_idle("single_end");

        // 3: back-to-back 1101 then 0110, no gap
        load_valid = 1'b1; load_data = 4'b1101;
        tick();
        frame(4'b1101, "b2b_a", 1'b1, 4'b0110);
        frame(4'b0110, "b2b_b", 1'b0, 4'h0);
        chk_idle("b2b_end");

        // 4: word offered at cycle +2 waits for the last-bit cycle
        load_valid = 1'b1; load_data = 4'b1101;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i == 1) begin
                load_valid = 1'b1;
                load_data  = 4'b1010;
            end
            chk($sformatf("stall_out%0d", i), {31'd0, ser_out},
                {31'd0, (i < 4) ? (i == 0 || i == 1 || i == 3) : 1'b1});
            chk($sformatf("stall_rdy%0d", i), {31'd0, load_ready}, {31'd0, (i == FRAME - 1)});
            tick();
        end
        frame(4'b1010, "stall_b", 1'b0, 4'h0);
        chk_idle("stall_end");

        // 5: reset after two bits truncates the frame
        load_valid = 1'b1; load_data = 4'b1101;
        tick();
        load_valid = 1'b0;
        chk("mid_out0", {31'd0, ser_out}, 32'd1);
        tick();
        chk("mid_out1", {31'd0, ser_out}, 32'd1);
        chk("mid_vld1", {31'd0, ser_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mid_rst");
        load_valid = 1'b1; load_data = 4'b0011;
        tick();
        frame(4'b0011, "after_rst", 1'b0, 4'h0);
        chk_idle("after_rst_end");

`ifdef PISO_PARITY_EN
        // 6: explicit parity bit values for 1101 (1) and 1001 (0)
        load_valid = 1'b1; load_data = 4'b1101;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        chk("par1101_bit", {31'd0, ser_out}, 32'd1);
        chk("par1101_last", {31'd0, ser_last}, 32'd1);
        tick();
        load_valid = 1'b1; load_data = 4'b1001;
        tick();
        load_valid = 1'b0;
        repeat (4) tick();
        chk("par1001_bit", {31'd0, ser_out}, 32'd0);
        chk("par1001_last", {31'd0, ser_last}, 32'd1);
        tick();
        chk_idle("par_end");
`else
        // 6 (no parity): 1001 ends on its data bit
        load_valid = 1'b1; load_data = 4'b1001;
        tick();
        frame(4'b1001, "np1001", 1'b0, 4'h0);
        chk_idle("np_end");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
